wrr_table_arbiter: RTL and testbench

Table-driven weighted round-robin arbiter: a programmable slot table of requester IDs is walked one slot per arbitration, and the requester named by the current slot is granted if it is requesting. It generalises the fixed 4-requester / 16-slot priority-table scheduler:
- requester count, ID width and table depth are parameters;
- the table is writable at runtime, and its active length is programmable;
- grants use a valid/ready handshake and are held until accepted.

It sits in front of the TLP transmit path, selecting which virtual channel / source queue sends next.

---
 rtl/wrr_table_arbiter.sv | 148 ++++++++++++++
 tb/tb_wrr_table_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/wrr_table_arbiter.sv
// Table-driven weighted round-robin arbiter with a runtime-writable slot table and valid/ready grants.
// Optional macro WRR_WORK_CONSERVING_EN: on a slot miss, search ahead for the next hitting slot.
module wrr_table_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic                  cfg_we,
    input  logic [DEPTH_LOG2-1:0] cfg_addr,
    input  logic [ID_W-1:0]       cfg_data,
    input  logic [DEPTH_LOG2:0]   tbl_len,
    input  logic                  grant_ready,
    output logic                  grant_valid,
    output logic [ID_W-1:0]       grant_id,
    output logic [NUM_REQ-1:0]    grant_onehot,
    output logic [DEPTH_LOG2-1:0] slot_ptr
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ID_W-1:0]       tbl [DEPTH];
    logic [ID_W-1:0]       id_nxt;
    logic [NUM_REQ-1:0]    onehot_nxt;
    logic [DEPTH_LOG2-1:0] ptr_nxt;
    logic [DEPTH_LOG2-1:0] eval_idx;
    int                    eff_len;
    int                    eval_slot;
    logic                  arb_en;

    // IDs outside the requester range are legal table contents but never hit.
    function automatic logic is_hit(input logic [ID_W-1:0] id, input logic [NUM_REQ-1:0] r);
        logic h;
        h = 1'b0;
        for (int q = 0; q < NUM_REQ; q++) begin
            if (int'(id) == q) h = r[q];
        end
        return h;
    endfunction

    function automatic logic [NUM_REQ-1:0] decode(input logic [ID_W-1:0] id);
        logic [NUM_REQ-1:0] d;
        d = '0;
        for (int q = 0; q < NUM_REQ; q++) begin
            if (int'(id) == q) d[q] = 1'b1;
        end
        return d;
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] wrap_inc(input int s, input int len);
        return (s + 1 >= len) ? '0 : DEPTH_LOG2'(s + 1);
    endfunction

    // A pointer stranded beyond a shortened table restarts from slot 0.
    always_comb begin
        eff_len = DEPTH;
        if (tbl_len != '0 && int'(tbl_len) <= DEPTH) eff_len = int'(tbl_len);
        eval_slot = (int'(slot_ptr) >= eff_len) ? 0 : int'(slot_ptr);
        eval_idx  = DEPTH_LOG2'(eval_slot);
    end

`ifdef WRR_WORK_CONSERVING_EN
    logic                  wc_found;
    logic [DEPTH_LOG2-1:0] wc_slot;

    always_comb begin
        wc_found = 1'b0;
        wc_slot  = '0;
        for (int k = 1; k < DEPTH; k++) begin
            int cand;
            cand = eval_slot + k;
            if (cand >= eff_len) cand = cand - eff_len;
            if (!wc_found && k < eff_len && is_hit(tbl[DEPTH_LOG2'(cand)], req)) begin
                wc_found = 1'b1;
                wc_slot  = DEPTH_LOG2'(cand);
            end
        end
    end
`endif

    // Table writes land at the edge, so a slot evaluated this cycle still sees its old entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= ID_W'(i % NUM_REQ);
            end
        end else if (cfg_we) begin
            tbl[cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            grant_id     <= '0;
            grant_onehot <= '0;
            slot_ptr     <= '0;
        end else begin
            state        <= state_nxt;
            grant_id     <= id_nxt;
            grant_onehot <= onehot_nxt;
            slot_ptr     <= ptr_nxt;
        end
    end

    // Accepting a grant re-arbitrates in the same cycle, giving bubble-free back-to-back grants.
    always_comb begin
        state_nxt = state;
        id_nxt    = grant_id;
        ptr_nxt   = slot_ptr;
        arb_en    = (state == IDLE) || grant_ready;

        if (arb_en) begin
            if (is_hit(tbl[eval_idx], req)) begin
                state_nxt = GRANT;
                id_nxt    = tbl[eval_idx];
                ptr_nxt   = wrap_inc(eval_slot, eff_len);
`ifdef WRR_WORK_CONSERVING_EN
            end else if (wc_found) begin
                state_nxt = GRANT;
                id_nxt    = tbl[wc_slot];
                ptr_nxt   = wrap_inc(int'(wc_slot), eff_len);
            end else begin
                state_nxt = IDLE;
            end
`else
            end else begin
                state_nxt = IDLE;
                ptr_nxt   = wrap_inc(eval_slot, eff_len);
            end
`endif
        end

        onehot_nxt = (state_nxt == GRANT) ? decode(id_nxt) : '0;
    end

    assign grant_valid = (state == GRANT);

endmodule

// File: tb/tb_wrr_table_arbiter.sv
// Randomized self-checking bench for wrr_table_arbiter against a slot-table reference model.
module tb_wrr_table_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DEPTH   = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic       cfg_we;
    logic [3:0] cfg_addr;
    logic [1:0] cfg_data;
    logic [4:0] tbl_len;
    logic       grant_ready;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic [3:0] grant_onehot;
    logic [3:0] slot_ptr;

    int checks   = 0;
    int failures = 0;

    int m_tbl [DEPTH];
    int m_ptr;
    bit m_valid;
    int m_id;

    wrr_table_arbiter #(.NUM_REQ(4), .ID_W(2), .DEPTH_LOG2(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .tbl_len      (tbl_len),
        .grant_ready  (grant_ready),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id),
        .grant_onehot (grant_onehot),
        .slot_ptr     (slot_ptr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic bit m_hit(input int id, input logic [3:0] r);
        if (id < 0 || id >= NUM_REQ) return 1'b0;
        return ((r >> id) & 4'd1) == 4'd1;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) m_tbl[i] = i % NUM_REQ;
        m_ptr   = 0;
        m_valid = 1'b0;
        m_id    = 0;
    endtask

    // One arbitration decision from the current model state and this cycle's inputs.
    task automatic modelStep(input logic [3:0] r, input logic rdy, input logic we,
                             input logic [3:0] addr, input logic [1:0] data, input logic [4:0] len);
        int eff;
        int e;
        int pick;
        eff  = (len == 0 || int'(len) > DEPTH) ? DEPTH : int'(len);
        e    = (m_ptr >= eff) ? 0 : m_ptr;
        pick = -1;
        if (!m_valid || rdy) begin
            if (m_hit(m_tbl[e], r)) pick = e;
`ifdef WRR_WORK_CONSERVING_EN
            for (int off = 1; off < eff; off++) begin
                if (pick < 0 && m_hit(m_tbl[(e + off) % eff], r)) pick = (e + off) % eff;
            end
`endif
            if (pick >= 0) begin
                m_valid = 1'b1;
                m_id    = m_tbl[pick];
                m_ptr   = (pick + 1) % eff;
            end else begin
                m_valid = 1'b0;
`ifndef WRR_WORK_CONSERVING_EN
                m_ptr   = (e + 1) % eff;
`endif
            end
        end
        if (we) m_tbl[addr] = int'(data);
    endtask

    task automatic compareAll();
        checkOutput("grant_valid", int'(grant_valid), int'(m_valid));
        if (m_valid) checkOutput("grant_id", int'(grant_id), m_id);
        checkOutput("grant_onehot", int'(grant_onehot), m_valid ? (1 << m_id) : 0);
        checkOutput("slot_ptr", int'(slot_ptr), m_ptr);
    endtask

    // Drive one cycle of inputs, advance the model, then sample after the edge.
    task automatic applyStimulus(input logic [3:0] r, input logic rdy, input logic we,
                                 input logic [3:0] addr, input logic [1:0] data, input logic [4:0] len);
        req         = r;
        grant_ready = rdy;
        cfg_we      = we;
        cfg_addr    = addr;
        cfg_data    = data;
        tbl_len     = len;
        modelStep(r, rdy, we, addr, data, len);
        @(posedge clk);
        #1;
        compareAll();
    endtask

    initial begin
        int n0;
        int n1;
        int n2;
        int hold_id;
        int hold_ptr;
        int wts [4];
        logic [4:0] cur_len;

        reset       = 1'b1;
        req         = '0;
        cfg_we      = 1'b0;
        cfg_addr    = '0;
        cfg_data    = '0;
        tbl_len     = '0;
        grant_ready = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        compareAll();

        // Default table, everyone requesting: plain rotation 0,1,2,3
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'b1111, 1'b1, 1'b0, 4'd0, 2'd0, 5'd0);
            checkOutput("rr_id", int'(grant_id), k % 4);
        end

        // Weighted 4-slot table {0,0,0,1}
        wts = '{0, 0, 0, 1};
        for (int i = 0; i < 4; i++)
            applyStimulus(4'b0000, 1'b1, 1'b1, 4'(i), 2'(wts[i]), 5'd4);
        n0 = 0;
        n1 = 0;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'b0011, 1'b1, 1'b0, 4'd0, 2'd0, 5'd4);
            if (grant_valid && grant_id == 2'd0) n0++;
            if (grant_valid && grant_id == 2'd1) n1++;
        end
        checkOutput("weight_id0", n0, 6);
        checkOutput("weight_id1", n1, 2);

        // Restore default table and request only ID 2
        for (int i = 0; i < 4; i++)
            applyStimulus(4'b0000, 1'b1, 1'b1, 4'(i), 2'(i), 5'd0);
        n2 = 0;
        for (int k = 0; k < 16; k++) begin
            applyStimulus(4'b0100, 1'b1, 1'b0, 4'd0, 2'd0, 5'd0);
            if (grant_valid && grant_id == 2'd2) n2++;
        end
`ifdef WRR_WORK_CONSERVING_EN
        checkOutput("sparse_grants", n2, 16);
`else
        checkOutput("sparse_grants", n2, 4);
`endif

        // Backpressure: grant and pointer frozen even when requests drop
        applyStimulus(4'b1111, 1'b1, 1'b0, 4'd0, 2'd0, 5'd0);
        hold_id  = m_id;
        hold_ptr = m_ptr;
        for (int k = 0; k < 5; k++) begin
            applyStimulus((k == 2) ? 4'b0000 : 4'($urandom), 1'b0, 1'b0, 4'd0, 2'd0, 5'd0);
            checkOutput("bp_hold_id", int'(grant_id), hold_id);
            checkOutput("bp_hold_ptr", int'(slot_ptr), hold_ptr);
            checkOutput("bp_hold_valid", int'(grant_valid), 1);
        end
        applyStimulus(4'b1111, 1'b1, 1'b0, 4'd0, 2'd0, 5'd0);

        // Corrupt slot 5, then reset mid-grant and confirm the default table returns
        applyStimulus(4'b1111, 1'b1, 1'b1, 4'd5, 2'd3, 5'd0);
        cfg_we   = 1'b1;
        cfg_addr = 4'd6;
        cfg_data = 2'd0;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rst_async_valid", int'(grant_valid), 0);
        checkOutput("rst_async_onehot", int'(grant_onehot), 0);
        cfg_we = 1'b0;
        #3;
        reset = 1'b0;
        modelReset();
        checkOutput("rst_ptr", int'(slot_ptr), 0);
        n1 = 0;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'b0010, 1'b1, 1'b0, 4'd0, 2'd0, 5'd0);
            if (grant_valid && grant_id == 2'd1) n1++;
        end
`ifdef WRR_WORK_CONSERVING_EN
        checkOutput("rst_table_grants", n1, 8);
`else
        checkOutput("rst_table_grants", n1, 2);
`endif

        // Randomized traffic with table writes and length changes
        cur_len = 5'd0;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 15) == 0) cur_len = 5'($urandom_range(0, 31));
            applyStimulus(4'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                          4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), cur_len);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
